// File: rtl/zap_mul_result_collector.sv
// rtl/zap_mul_result_collector.sv - multiply result capture, flag update and writeback FIFO
module zap_mul_result_collector #(
  parameter  int PHY_REGS = 46,
  parameter  int DEPTH    = 2,
  parameter  int MAX_LAT  = 8,
  localparam int IW       = $clog2(PHY_REGS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_stall,
  input  logic          i_start,
  input  logic [IW-1:0] i_dest_idx,
  input  logic          i_set_flags,
  input  logic          i_sat_en,
  input  logic [3:0]    i_flags,
  input  logic          i_q,
  input  logic          i_mul_busy,
  input  logic [31:0]   i_mul_rd,
  input  logic          i_mul_sat,
  input  logic          i_mul_nozero,
  output logic          o_stall,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [IW-1:0] o_wb_idx,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_flags,
  output logic          o_wb_q,
  output logic          o_timeout
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int LW  = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [31:0]   data;
    logic [3:0]    flags;
    logic          q;
  } rec_t;

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] op_idx_q, op_idx_d;
  logic          op_set_q, op_set_d;
  logic          op_sat_q, op_sat_d;
  logic [3:0]    op_flags_q, op_flags_d;
  logic          op_qf_q, op_qf_d;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          valid_q, valid_d;
  rec_t          head_q, head_d;
  logic          timeout_q, timeout_d;

  logic          full;
  logic          push;
  logic          pop;
  rec_t          rec;

  assign full    = (count_q == CW'(DEPTH));
  assign o_stall = full | (state_q == WAIT) | i_reset;

  // Next-state logic: FSM, latched op fields, FIFO pointers and registered head view
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_idx_d   = op_idx_q;
    op_set_d   = op_set_q;
    op_sat_d   = op_sat_q;
    op_flags_d = op_flags_q;
    op_qf_d    = op_qf_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    timeout_d  = 1'b0;
    push       = 1'b0;
    pop        = valid_q & i_ready;

    rec.idx      = op_idx_q;
    rec.data     = i_mul_rd;
    rec.flags[3] = op_set_q ? i_mul_rd[31] : op_flags_q[3];
    rec.flags[2] = op_set_q ? ((i_mul_rd == 32'd0) & ~i_mul_nozero) : op_flags_q[2];
    rec.flags[1:0] = op_flags_q[1:0];
    rec.q        = op_qf_q | (op_sat_q & i_mul_sat);

    if (i_clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (!i_stall) begin
        case (state_q)
          IDLE: begin
            if (i_start && !full) begin
              op_idx_d   = i_dest_idx;
              op_set_d   = i_set_flags;
              op_sat_d   = i_sat_en;
              op_flags_d = i_flags;
              op_qf_d    = i_q;
              cnt_d      = '0;
              state_d    = WAIT;
            end
          end
          WAIT: begin
            if (!i_mul_busy) begin
              push    = 1'b1;
              state_d = IDLE;
            end else if (cnt_q == LW'(MAX_LAT - 1)) begin
              timeout_d = 1'b1;
              state_d   = IDLE;
            end else begin
              cnt_d = cnt_q + LW'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
      if (push) begin
        mem_d[wr_ptr_q] = rec;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    valid_d = (count_d != '0);
    head_d  = (valid_d) ? mem_d[rd_ptr_d] : '0;
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_idx_q   <= '0;
      op_set_q   <= 1'b0;
      op_sat_q   <= 1'b0;
      op_flags_q <= '0;
      op_qf_q    <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_idx_q   <= op_idx_d;
      op_set_q   <= op_set_d;
      op_sat_q   <= op_sat_d;
      op_flags_q <= op_flags_d;
      op_qf_q    <= op_qf_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      timeout_q  <= timeout_d;
    end
  end

  // FIFO storage; contents are only meaningful behind a nonzero count
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_valid    = valid_q;
  assign o_wb_idx   = head_q.idx;
  assign o_wb_data  = head_q.data;
  assign o_wb_flags = head_q.flags;
  assign o_wb_q     = head_q.q;
  assign o_timeout  = timeout_q;

endmodule
